sva_thread_sched: RTL and testbench
===================================

// Module: sva_thread_sched
// PURPOSE
//  Slot scheduler for concurrent assertion-attempt threads in the gclk domain. Each gclk cycle may start a new attempt; the
//  block grants it a free evaluation slot and a start timestamp, tracks busy/pending slots, and serialises per-slot results
//  (succ/fail/lazy_succ) onto one valid/ready result port via round-robin arbitration. Sits between the attempt generator and
//  the per-slot SVA FSM evaluators, feeding the result logger.
// PARAMETERS
//  NUM_SLOTS    4   number of concurrent evaluation slots (>=2)
//  TIMER_WIDTH  8   width of free-running start-period timer
//  CNT_WIDTH    16  width of saturating overflow counter
//  SLOT_W       derived: $clog2(NUM_SLOTS), minimum 1
// PORTS
//  gclk          in   1                 user clock
//  grst          in   1                 reset, asynchronous, active-high
//  start_req     in   1                 new attempt starts this cycle
//  start_gnt     out  1                 attempt granted a slot (combinational from start_req, busy_vec)
//  start_slot    out  SLOT_W            granted slot index (valid when start_gnt)
//  start_stamp   out  TIMER_WIDTH       timer value at grant
//  done_vec      in   NUM_SLOTS         slot i finished this cycle
//  done_code     in   2*NUM_SLOTS       slot i code at [2i+1:2i]: 01 succ, 10 fail, 11 lazy_succ, 00 illegal
//  res_valid     out  1                 result available
//  res_ready     in   1                 consumer accepts result
//  res_slot      out  SLOT_W            slot of presented result
//  res_code      out  2                 code of presented result
//  res_stamp     out  TIMER_WIDTH       start timestamp of that attempt
//  busy_vec      out  NUM_SLOTS         slot occupied (evaluating or result pending)
//  overflow_cnt  out  CNT_WIDTH         attempts refused for lack of slot, saturating
//  err_sticky    out  1                 protocol error seen (done on idle/pending slot, code 00)
// BEHAVIOUR
//  - Reset: timer, busy, pending, res_valid, res_slot/code/stamp, overflow_cnt, err_sticky, rr pointer all 0; output FSM R_IDLE.
//  - timer: +1 every gclk, wraps at 2^TIMER_WIDTH-1 -> 0.
//  - Alloc: start_req & any ~busy -> start_gnt=1, start_slot = lowest free index, start_stamp = timer; slot busy and stamp
//    stored at that edge. No free slot -> start_gnt=0, overflow_cnt+1 (holds at all-ones).
//  - Done: done_vec[i] on busy, non-pending slot -> pending[i] set, code latched at edge. done on idle or already-pending slot
//    -> ignored, err_sticky=1. Code 00 -> latched as 10 (fail), err_sticky=1. err_sticky cleared only by grst.
//  - Output FSM R_IDLE/R_VALID. R_IDLE & any pending -> load res_* from rr winner, res_valid=1, -> R_VALID (done at edge k
//    gives res_valid after edge k+1). R_VALID: res_* held stable until res_ready. On res_valid&res_ready: winner's pending
//    and busy cleared, rr pointer = winner+1 (mod NUM_SLOTS); if another pending exists load it same edge (back-to-back),
//    else -> R_IDLE.
//  - Round-robin: search starts at rr pointer, first pending index wins; slot currently presented excluded from next search.
//  - Freed slot allocatable the cycle after the accepting edge (no same-cycle reuse). Allocation and done/accept on
//    different slots in one cycle all take effect.
//  - A slot cannot receive done in the cycle it is granted (not yet busy) -> treated as error.
//  - grst mid-operation: all in-flight and pending results discarded, outputs to reset values immediately.
// STRUCTURE
//  - Package sva_sched_pkg: res_code_t enum {RC_ILL=0, RC_SUCC=1, RC_FAIL=2, RC_LAZY=3}; out_fsm_t enum {R_IDLE, R_VALID}.
//  - Sub-module sva_rr_arbiter (NUM_SLOTS): req vector + pointer in, one-hot grant + index + any out; combinational.
//  - Top: timer, busy/pending/stamp/code arrays, priority-encoder allocator, output FSM, counters.
// TESTING
//  1. grst, then start_req=1 for 4 cycles, NUM_SLOTS=4 -> start_slot 0,1,2,3, stamps 0,1,2,3; busy_vec=4'b1111.
//  2. All busy, start_req=1 for 3 cycles -> start_gnt=0, overflow_cnt=3; force to 2^16-1 -> stays 16'hFFFF.
//  3. done_vec=4'b1010 codes succ/fail, res_ready=1 -> res_slot 1 (succ) then 3 (fail) back-to-back; busy_vec clears bits 1,3.
//  4. res_ready=0 with slot 2 pending for 5 cycles -> res_* stable; done on slot 0 meanwhile -> presented next after accept.
//  5. done_vec[1] on idle slot, or code 00 on busy slot 2 -> err_sticky=1; slot 2 reported res_code=2'b10.
//  6. grst asserted while res_valid=1 and 3 slots busy -> res_valid=0, busy_vec=0 immediately; next start_req gets slot 0.

Source files
------------

// File: rtl/sva_sched_pkg.sv
// Shared types for the assertion-attempt slot scheduler.
package sva_sched_pkg;

  // Result code reported by a per-slot evaluator.
  typedef enum logic [1:0] {
    RC_ILL  = 2'd0,
    RC_SUCC = 2'd1,
    RC_FAIL = 2'd2,
    RC_LAZY = 2'd3
  } res_code_t;

  // Result-port state.
  typedef enum logic {
    R_IDLE  = 1'b0,
    R_VALID = 1'b1
  } out_fsm_t;

  // An illegal code is recorded as a failure so the logger never sees 00.
  function automatic res_code_t sanitize_code(input logic [1:0] code);
    return (code == 2'b00) ? RC_FAIL : res_code_t'(code);
  endfunction

endpackage

// File: rtl/sva_thread_sched_arbiter.sv
// Round-robin picker: first requesting index at or after i_ptr (wrapping).
module sva_rr_arbiter
  import sva_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic [NUM_SLOTS-1:0] i_req,
  input  logic [SLOT_W-1:0]    i_ptr,
  output logic [NUM_SLOTS-1:0] o_gnt,
  output logic [SLOT_W-1:0]    o_idx,
  output logic                 o_any
);

  logic [2*NUM_SLOTS-1:0] w_rot;
  int                     w_sum;

  // Rotate the request vector so that i_ptr lands at bit 0, then take the lowest set bit.
  always_comb begin
    // NOTE: every output gets a default before any branch, otherwise paths that skip an assignment infer latches.
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_sum = 0;
    w_rot = {i_req, i_req} >> i_ptr;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (!o_any && w_rot[k]) begin
        o_any = 1'b1;
        w_sum = int'(i_ptr) + k;
        if (w_sum >= NUM_SLOTS) w_sum = w_sum - NUM_SLOTS;
        o_idx = SLOT_W'(w_sum);
      end
    end
    if (o_any) o_gnt = NUM_SLOTS'(1) << o_idx;
  end

endmodule

// File: rtl/sva_thread_sched.sv
// Slot scheduler for concurrent assertion attempts: allocates slots, stamps starts,
// collects per-slot results and serialises them onto one valid/ready port.
module sva_thread_sched
  import sva_sched_pkg::*;
#(
  parameter int NUM_SLOTS   = 4,
  parameter int TIMER_WIDTH = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                   gclk,
  input  logic                   grst,
  input  logic                   start_req,
  output logic                   start_gnt,
  output logic [SLOT_W-1:0]      start_slot,
  output logic [TIMER_WIDTH-1:0] start_stamp,
  input  logic [NUM_SLOTS-1:0]   done_vec,
  input  logic [2*NUM_SLOTS-1:0] done_code,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SLOT_W-1:0]      res_slot,
  output logic [1:0]             res_code,
  output logic [TIMER_WIDTH-1:0] res_stamp,
  output logic [NUM_SLOTS-1:0]   busy_vec,
  output logic [CNT_WIDTH-1:0]   overflow_cnt,
  output logic                   err_sticky
);

  out_fsm_t               r_state, w_state_nxt;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic [NUM_SLOTS-1:0]   r_busy, r_pending;
  logic [TIMER_WIDTH-1:0] r_stamp [NUM_SLOTS];
  res_code_t              r_code  [NUM_SLOTS];
  logic [SLOT_W-1:0]      r_res_slot, r_rr_ptr;
  res_code_t              r_res_code;
  logic [TIMER_WIDTH-1:0] r_res_stamp;
  logic [CNT_WIDTH-1:0]   r_ovf;
  logic                   r_err;

  logic                   w_any_free, w_accept, w_load, w_err_evt;
  logic [SLOT_W-1:0]      w_free_idx, w_next_ptr, w_arb_ptr, w_arb_idx;
  logic [NUM_SLOTS-1:0]   w_alloc_oh, w_acc_oh, w_pres_oh, w_done_ok, w_code_zero;
  logic [NUM_SLOTS-1:0]   w_arb_req, w_arb_gnt;
  logic                   w_arb_any;

  // Allocator: lowest free slot; done qualification against the current busy/pending state.
  always_comb begin
    w_free_idx  = '0;
    w_code_zero = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = SLOT_W'(i);
      w_code_zero[i] = (done_code[2*i +: 2] == 2'b00);
    end
  end

  assign w_any_free = ~&r_busy;
  assign start_gnt  = start_req & w_any_free;
  assign w_alloc_oh = start_gnt ? (NUM_SLOTS'(1) << w_free_idx) : '0;
  assign w_done_ok  = done_vec & r_busy & ~r_pending;
  assign w_err_evt  = (|(done_vec & ~w_done_ok)) | (|(w_done_ok & w_code_zero));

  // The slot on the port is excluded from the next search, which begins just past it.
  assign w_accept   = (r_state == R_VALID) && res_ready;
  assign w_pres_oh  = NUM_SLOTS'(1) << r_res_slot;
  assign w_acc_oh   = w_accept ? w_pres_oh : '0;
  assign w_next_ptr = (r_res_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : r_res_slot + SLOT_W'(1);
  assign w_arb_ptr  = (r_state == R_VALID) ? w_next_ptr : r_rr_ptr;
  assign w_arb_req  = r_pending & ((r_state == R_VALID) ? ~w_pres_oh : '1);

  sva_rr_arbiter #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_arb (
    .i_req (w_arb_req),
    .i_ptr (w_arb_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  // Result-port next state and load decision.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (w_arb_any) begin
          w_load      = 1'b1;
          w_state_nxt = R_VALID;
        end
      end
      R_VALID: begin
        if (res_ready) begin
          if (w_arb_any) w_load = 1'b1;
          else           w_state_nxt = R_IDLE;
        end
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

  // Result-port state register.
  always_ff @(posedge gclk or posedge grst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (grst) r_state <= R_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Per-slot start stamp and result code, written on grant and on accepted done.
  always_ff @(posedge gclk) begin
    // NOTE: this storage is not reset; it is only read for slots whose busy/pending bits are set.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_alloc_oh[i]) r_stamp[i] <= r_timer;
      if (w_done_ok[i])  r_code[i]  <= sanitize_code(done_code[2*i +: 2]);
    end
  end

  // Timer, slot bookkeeping, presented result, rr pointer, overflow counter and error flag.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      r_timer     <= '0;
      r_busy      <= '0;
      r_pending   <= '0;
      r_res_slot  <= '0;
      r_res_code  <= RC_ILL;
      r_res_stamp <= '0;
      r_rr_ptr    <= '0;
      r_ovf       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_timer   <= r_timer + TIMER_WIDTH'(1);
      r_busy    <= (r_busy & ~w_acc_oh) | w_alloc_oh;
      r_pending <= (r_pending & ~w_acc_oh) | w_done_ok;
      if (w_load) begin
        r_res_slot  <= w_arb_idx;
        r_res_code  <= r_code[w_arb_idx];
        r_res_stamp <= r_stamp[w_arb_idx];
      end
      if (w_accept) r_rr_ptr <= w_next_ptr;
      if (start_req && !w_any_free && (r_ovf != '1)) r_ovf <= r_ovf + CNT_WIDTH'(1);
      if (w_err_evt) r_err <= 1'b1;
    end
  end

  assign start_slot   = w_free_idx;
  assign start_stamp  = r_timer;
  assign res_valid    = (r_state == R_VALID);
  assign res_slot     = r_res_slot;
  assign res_code     = r_res_code;
  assign res_stamp    = r_res_stamp;
  assign busy_vec     = r_busy;
  assign overflow_cnt = r_ovf;
  assign err_sticky   = r_err;

endmodule

// File: tb/tb_sva_thread_sched.sv
// Self-checking bench for sva_thread_sched: directed scenarios followed by random traffic,
// compared against a slot-level reference model and a result scoreboard.
module tb_sva_thread_sched;

  localparam int N  = 4;
  localparam int TW = 8;
  localparam int CW = 4;   // narrow overflow counter so saturation is reachable quickly
  localparam int SW = 2;
  localparam int OVF_MAX = (1 << CW) - 1;
  localparam int T_MOD   = 1 << TW;

  logic          gclk = 1'b0;
  logic          grst;
  logic          start_req, start_gnt;
  logic [SW-1:0] start_slot;
  logic [TW-1:0] start_stamp;
  logic [N-1:0]  done_vec;
  logic [2*N-1:0] done_code;
  logic          res_valid, res_ready;
  logic [SW-1:0] res_slot;
  logic [1:0]    res_code;
  logic [TW-1:0] res_stamp;
  logic [N-1:0]  busy_vec;
  logic [CW-1:0] overflow_cnt;
  logic          err_sticky;

  always #5 gclk = ~gclk;

  sva_thread_sched #(
    .NUM_SLOTS   (N),
    .TIMER_WIDTH (TW),
    .CNT_WIDTH   (CW)
  ) dut (
    .gclk         (gclk),
    .grst         (grst),
    .start_req    (start_req),
    .start_gnt    (start_gnt),
    .start_slot   (start_slot),
    .start_stamp  (start_stamp),
    .done_vec     (done_vec),
    .done_code    (done_code),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_slot     (res_slot),
    .res_code     (res_code),
    .res_stamp    (res_stamp),
    .busy_vec     (busy_vec),
    .overflow_cnt (overflow_cnt),
    .err_sticky   (err_sticky)
  );

  typedef struct {
    int slot;
    int code;
    int stamp;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: what each slot holds and what the result port shows.
  logic [N-1:0] m_busy = '0, m_pend = '0;
  int   m_stamp [N];
  int   m_code  [N];
  int   m_timer = 0, m_ovf = 0, m_rr = 0, m_pres_slot = 0;
  logic m_err = 1'b0, m_pres_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int from);
    for (int k = 0; k < N; k++) begin
      if (req[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  // Model: compare current outputs, then advance to the state after the coming edge.
  always @(negedge gclk) begin
    int fs, pick, s, c;
    logic [N-1:0] old_busy, old_pend;
    exp_t e;
    if (grst) begin
      m_busy = '0; m_pend = '0; m_timer = 0; m_ovf = 0; m_rr = 0;
      m_err = 1'b0; m_pres_valid = 1'b0; m_pres_slot = 0;
      exp_q.delete();
      check("rst_busy",  32'(busy_vec), 0);
      check("rst_valid", 32'(res_valid), 0);
      check("rst_ovf",   32'(overflow_cnt), 0);
      check("rst_err",   32'(err_sticky), 0);
    end else begin
      fs = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) fs = i;
      check("start_gnt", 32'(start_gnt), (start_req && fs >= 0) ? 1 : 0);
      if (start_req && fs >= 0) begin
        check("start_slot",  32'(start_slot), fs);
        check("start_stamp", 32'(start_stamp), m_timer);
      end
      check("busy_vec",     32'(busy_vec), 32'(m_busy));
      check("overflow_cnt", 32'(overflow_cnt), m_ovf);
      check("err_sticky",   32'(err_sticky), 32'(m_err));
      check("res_valid",    32'(res_valid), 32'(m_pres_valid));
      if (m_pres_valid) begin
        check("res_slot_hold",  32'(res_slot), m_pres_slot);
        check("res_code_hold",  32'(res_code), m_code[m_pres_slot]);
        check("res_stamp_hold", 32'(res_stamp), m_stamp[m_pres_slot]);
      end

      old_busy = m_busy;
      old_pend = m_pend;
      pick = -1;
      if (!m_pres_valid) begin
        pick = rr_pick(old_pend, m_rr);
      end else if (res_ready) begin
        s = m_pres_slot;
        m_busy[s] = 1'b0;
        m_pend[s] = 1'b0;
        m_rr = (s + 1) % N;
        pick = rr_pick(old_pend & ~(N'(1) << s), m_rr);
        if (pick < 0) m_pres_valid = 1'b0;
      end
      if (pick >= 0) begin
        m_pres_valid = 1'b1;
        m_pres_slot  = pick;
        e.slot = pick; e.code = m_code[pick]; e.stamp = m_stamp[pick];
        exp_q.push_back(e);
      end
      for (int i = 0; i < N; i++) begin
        if (done_vec[i]) begin
          if (old_busy[i] && !old_pend[i]) begin
            c = int'(done_code[2*i +: 2]);
            if (c == 0) begin c = 2; m_err = 1'b1; end
            m_pend[i] = 1'b1;
            m_code[i] = c;
          end else begin
            m_err = 1'b1;
          end
        end
      end
      if (start_req && fs >= 0) begin
        m_busy[fs]  = 1'b1;
        m_stamp[fs] = m_timer;
      end
      if (start_req && fs < 0 && m_ovf < OVF_MAX) m_ovf++;
      m_timer = (m_timer + 1) % T_MOD;
    end
  end

  // Monitor: every accepted result must be the oldest expected one.
  always @(negedge gclk) begin
    exp_t e;
    if (!grst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_pop: slot %0d accepted, expected no result", res_slot);
      end else begin
        e = exp_q.pop_front();
        check("sb_slot",  32'(res_slot), e.slot);
        check("sb_code",  32'(res_code), e.code);
        check("sb_stamp", 32'(res_stamp), e.stamp);
      end
    end
  end

  task automatic drive(input logic s, input logic [N-1:0] dv, input logic [2*N-1:0] dc, input logic rdy);
    @(posedge gclk);
    #1;
    start_req = s; done_vec = dv; done_code = dc; res_ready = rdy;
  endtask

  task automatic do_reset();
    @(posedge gclk);
    #1;
    grst = 1'b1;
    start_req = 1'b0; done_vec = '0; done_code = '0; res_ready = 1'b0;
    repeat (2) @(posedge gclk);
    #1;
    grst = 1'b0;
  endtask

  initial begin
    logic [N-1:0]   dv;
    logic [2*N-1:0] dc;
    grst = 1'b1;
    start_req = 1'b0; done_vec = '0; done_code = '0; res_ready = 1'b0;
    repeat (3) @(posedge gclk);

    // Fill all four slots right out of reset: slots 0..3, stamps 0..3.
    #1;
    grst = 1'b0;
    start_req = 1'b1;
    repeat (3) drive(1'b1, '0, '0, 1'b0);
    // All busy: refused attempts count up and saturate.
    repeat (20) drive(1'b1, '0, '0, 1'b0);

    // Slots 1 (succ) and 3 (fail) finish together; accepted back to back.
    drive(1'b0, 4'b1010, 8'b10_00_01_00, 1'b1);
    repeat (4) drive(1'b0, '0, '0, 1'b1);

    // Slot 2 result held while the consumer stalls; slot 0 finishes meanwhile.
    drive(1'b0, 4'b0100, 8'b00_01_00_00, 1'b0);
    drive(1'b0, 4'b0001, 8'b00_00_00_11, 1'b0);
    repeat (4) drive(1'b0, '0, '0, 1'b0);
    repeat (4) drive(1'b0, '0, '0, 1'b1);

    // Done on an idle slot, then code 00 on busy slot 2.
    drive(1'b0, 4'b0010, 8'b00_00_01_00, 1'b1);
    repeat (3) drive(1'b1, '0, '0, 1'b1);
    drive(1'b0, 4'b0100, 8'b00_00_00_00, 1'b1);
    repeat (4) drive(1'b0, '0, '0, 1'b1);

    // Reset while a result is presented and three slots are busy.
    drive(1'b1, '0, '0, 1'b0);
    drive(1'b0, 4'b0001, 8'b00_00_00_01, 1'b0);
    repeat (2) drive(1'b0, '0, '0, 1'b0);
    do_reset();
    drive(1'b1, '0, '0, 1'b1);

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        dv = m_busy & ~m_pend & N'($urandom) & N'($urandom);
        if ($urandom_range(0, 49) == 0) dv[$urandom_range(0, N - 1)] = 1'b1;
        for (int i = 0; i < N; i++)
          dc[2*i +: 2] = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        drive(1'($urandom_range(0, 1)), dv, dc, ($urandom_range(0, 9) < 7));
      end
    end

    // Drain outstanding results.
    repeat (20) drive(1'b0, '0, '0, 1'b1);
    @(negedge gclk);
    check("sb_drain", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
